// File: rtl/stack_seq_pkg.sv
// -----------------------------------------------------------------------------
// stack_seq_pkg
//   Shared encodings for the MSP430 stack sequencer:
//     - op_e    : operation codes presented on stack_seq.op (6-7 are reserved)
//     - msp_e   : select driven to the external SP-update mux
//     - state_e : sequencer states
//   Helper functions:
//     - seq_state()      : state to visit at a given step of an operation
//     - op_is_reserved() : true for the two unused op codes
//     - op_loads_pc()    : operations that end with a PC load strobe
// -----------------------------------------------------------------------------
package stack_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_CALL = 3'd3,
      OP_RETI = 3'd4,
      OP_IRQ  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      MSP_HOLD = 2'd0,
      MSP_DEC  = 2'd1,
      MSP_INC  = 2'd2
   } msp_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DEC  = 3'd1,
      S_WR   = 3'd2,
      S_RD   = 3'd3,
      S_INC  = 3'd4,
      S_VEC  = 3'd5,
      S_FIN  = 3'd6
   } state_e;

   // The longest sequence (IRQ) has six steps, so three bits cover every step.
   localparam int STEP_W = 3;
   typedef logic [STEP_W-1:0] step_t;

   // Sequence tables. Every operation ends in FIN; NOP and the reserved
   // codes go straight there.
   function automatic state_e seq_state(input logic [2:0] op, input step_t step);
      state_e s;
      s = S_FIN;
      case (op)
         OP_PUSH, OP_CALL: begin
            case (step)
               3'd0:    s = S_DEC;
               3'd1:    s = S_WR;
               default: s = S_FIN;
            endcase
         end
         OP_POP: begin
            case (step)
               3'd0:    s = S_RD;
               3'd1:    s = S_INC;
               default: s = S_FIN;
            endcase
         end
         OP_RETI: begin
            case (step)
               3'd0:    s = S_RD;
               3'd1:    s = S_INC;
               3'd2:    s = S_RD;
               3'd3:    s = S_INC;
               default: s = S_FIN;
            endcase
         end
         OP_IRQ: begin
            case (step)
               3'd0:    s = S_DEC;
               3'd1:    s = S_WR;
               3'd2:    s = S_DEC;
               3'd3:    s = S_WR;
               3'd4:    s = S_VEC;
               default: s = S_FIN;
            endcase
         end
         default: s = S_FIN;
      endcase
      return s;
   endfunction

   function automatic logic op_is_reserved(input logic [2:0] op);
      return op > OP_IRQ;
   endfunction

   function automatic logic op_loads_pc(input logic [2:0] op);
      return (op == OP_CALL) || (op == OP_RETI) || (op == OP_IRQ);
   endfunction

endpackage

// File: rtl/stack_seq_wait_timer.sv
// -----------------------------------------------------------------------------
// stack_wait_timer
//   Counts consecutive memory-request cycles without an acknowledge and flags
//   the cycle in which the MAX_WAIT-th unacknowledged request is being made.
//   An ack in that same cycle wins over the timeout. MAX_WAIT = 0 disables it.
//
//   Ports:
//     clk       in   core clock
//     rst       in   synchronous, active-high reset
//     busy_i    in   sequencer is in a request state (WR/RD/VEC)
//     ack_i     in   memory acknowledge for the current request
//     expired_o out  current request has hit the wait limit without ack
// -----------------------------------------------------------------------------
module stack_wait_timer #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic busy_i,
   input  logic ack_i,
   output logic expired_o
);

   // The counter only ever holds 0..MAX_WAIT-1; it clears instead of
   // reaching MAX_WAIT, so $clog2(MAX_WAIT) bits are enough.
   localparam int unsigned CW      = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam int unsigned LIMIT   = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
   localparam bit          ENABLED = (MAX_WAIT != 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      expired_o = ENABLED && busy_i && !ack_i && (cnt_q == CW'(LIMIT));
      // Leaving a request state, or completing one, restarts the count, so the
      // first cycle of every new transfer always sees zero.
      if (!busy_i || ack_i || expired_o || !ENABLED) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//   Multi-cycle stack sequencer for the MSP430 core. Runs PUSH, POP, CALL,
//   RETI and interrupt entry as a sequence of single-purpose steps: each step
//   either drives the SP-update mux select (MSP, with sp_we) or performs one
//   16-bit memory transfer at the current stack pointer. The SP register and
//   its +/-2 mux live outside this block; sp_in is the live register value.
//
//   Ports:
//     clk, rst                  core clock, synchronous active-high reset
//     op_valid/op_ready/op      request handshake; op sampled at accept
//     push_data, call_target,
//     irq_vec, pc_in, sr_in     operands, sampled at accept
//     sp_in                     live SP value (not sampled)
//     MSP, sp_we                SP mux select / SP write enable
//     mem_req, mem_we,
//     mem_addr, mem_wdata       memory request (address always even)
//     mem_rdata, mem_ack        memory response; rdata valid with ack
//     pop_data                  last POP result, held until the next POP
//     pc_out/pc_we              new PC with one-cycle load strobe
//     sr_out/sr_we              new SR with one-cycle load strobe
//     done, err                 completion pulse; err flags reserved op/timeout
// -----------------------------------------------------------------------------
module stack_seq
   import stack_seq_pkg::*;
#(
   parameter int          DW       = 16,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op,
   input  logic [DW-1:0] push_data,
   input  logic [DW-1:0] call_target,
   input  logic [DW-1:0] irq_vec,
   input  logic [DW-1:0] pc_in,
   input  logic [DW-1:0] sr_in,
   input  logic [DW-1:0] sp_in,
   output logic [1:0]    MSP,
   output logic          sp_we,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [DW-1:0] pop_data,
   output logic [DW-1:0] pc_out,
   output logic          pc_we,
   output logic [DW-1:0] sr_out,
   output logic          sr_we,
   output logic          done,
   output logic          err
);

   // Word alignment: clearing bit 0 makes an odd SP or vector behave as even.
   localparam logic [DW-1:0] ALIGN_MASK = ~DW'(1);

   state_e        state_q, state_d;
   step_t         step_q, step_d;
   step_t         next_step;
   logic          err_q, err_d;
   logic [DW-1:0] pop_data_q, pop_data_d;
   logic [DW-1:0] pc_out_q, pc_out_d;
   logic [DW-1:0] sr_out_q, sr_out_d;

   // Operands captured when a request is accepted.
   logic [2:0]    op_q;
   logic [DW-1:0] push_q;
   logic [DW-1:0] call_q;
   logic [DW-1:0] vec_q;
   logic [DW-1:0] pc_q;
   logic [DW-1:0] sr_q;

   logic          accept;
   logic          wait_busy;
   logic          wait_expired;
   logic [DW-1:0] wr_data;

   assign accept    = (state_q == S_IDLE) && op_valid;
   assign next_step = step_q + STEP_W'(1);

   // PUSH writes its operand; CALL and the first IRQ write save the PC; the
   // second IRQ write (step 3) saves the SR.
   assign wr_data = (op_q == OP_PUSH)                      ? push_q :
                    ((op_q == OP_IRQ) && (step_q == 3'd3)) ? sr_q   :
                                                             pc_q;

   stack_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .busy_i    (wait_busy),
      .ack_i     (mem_ack),
      .expired_o (wait_expired)
   );

   // NOTE: every signal written here gets a default before the case statement,
   // so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      err_d      = err_q;
      pop_data_d = pop_data_q;
      pc_out_d   = pc_out_q;
      sr_out_d   = sr_out_q;

      op_ready  = 1'b0;
      MSP       = MSP_HOLD;
      sp_we     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      pc_we     = 1'b0;
      sr_we     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      wait_busy = 1'b0;

      case (state_q)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               step_d  = '0;
               err_d   = op_is_reserved(op);
               state_d = seq_state(op, '0);
            end
         end

         S_DEC: begin
            MSP     = MSP_DEC;
            sp_we   = 1'b1;
            step_d  = next_step;
            state_d = seq_state(op_q, next_step);
         end

         S_INC: begin
            MSP     = MSP_INC;
            sp_we   = 1'b1;
            step_d  = next_step;
            state_d = seq_state(op_q, next_step);
         end

         // SP is not written while a transfer is pending, so the address
         // taken from sp_in stays stable until the ack.
         S_WR: begin
            wait_busy = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_in & ALIGN_MASK;
            mem_wdata = wr_data;
            if (mem_ack) begin
               if (op_q == OP_CALL) begin
                  pc_out_d = call_q;
               end
               step_d  = next_step;
               state_d = seq_state(op_q, next_step);
            end else if (wait_expired) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end

         S_RD: begin
            wait_busy = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = sp_in & ALIGN_MASK;
            if (mem_ack) begin
               case (op_q)
                  OP_POP: pop_data_d = mem_rdata;
                  // RETI pops SR first (step 0), then PC (step 2).
                  OP_RETI: begin
                     if (step_q == 3'd0) begin
                        sr_out_d = mem_rdata;
                     end else begin
                        pc_out_d = mem_rdata;
                     end
                  end
                  default: ;
               endcase
               step_d  = next_step;
               state_d = seq_state(op_q, next_step);
            end else if (wait_expired) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end

         S_VEC: begin
            wait_busy = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = vec_q & ALIGN_MASK;
            if (mem_ack) begin
               pc_out_d = mem_rdata;
               step_d   = next_step;
               state_d  = seq_state(op_q, next_step);
            end else if (wait_expired) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end

         // Load strobes are suppressed on error so a timed-out sequence never
         // hands a half-fetched PC or SR to the core.
         S_FIN: begin
            done    = 1'b1;
            err     = err_q;
            pc_we   = !err_q && op_loads_pc(op_q);
            sr_we   = !err_q && (op_q == OP_RETI);
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         err_q      <= 1'b0;
         pop_data_q <= '0;
         pc_out_q   <= '0;
         sr_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         err_q      <= err_d;
         pop_data_q <= pop_data_d;
         pc_out_q   <= pc_out_d;
         sr_out_q   <= sr_out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_NOP;
         push_q <= '0;
         call_q <= '0;
         vec_q  <= '0;
         pc_q   <= '0;
         sr_q   <= '0;
      end else if (accept) begin
         op_q   <= op;
         push_q <= push_data;
         call_q <= call_target;
         vec_q  <= irq_vec;
         pc_q   <= pc_in;
         sr_q   <= sr_in;
      end
   end

   assign pop_data = pop_data_q;
   assign pc_out   = pc_out_q;
   assign sr_out   = sr_out_q;

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;
   import stack_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        op_valid, op_ready;
   logic [2:0]  op;
   logic [15:0] push_data, call_target, irq_vec, pc_in, sr_in, sp_in;
   logic [1:0]  MSP;
   logic        sp_we, mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] pop_data, pc_out, sr_out;
   logic        pc_we, sr_we, done, err;

   stack_seq #(.DW(16), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .push_data(push_data), .call_target(call_target), .irq_vec(irq_vec),
      .pc_in(pc_in), .sr_in(sr_in), .sp_in(sp_in), .MSP(MSP), .sp_we(sp_we),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pop_data(pop_data), .pc_out(pc_out), .pc_we(pc_we), .sr_out(sr_out),
      .sr_we(sr_we), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External SP register with its +/-2 mux; odd values are treated as even.
   logic [15:0] sp_q, sp_load_val;
   logic        sp_load;
   always @(posedge clk) begin
      if (sp_load) sp_q <= sp_load_val;
      else if (sp_we) begin
         case (MSP)
            2'd1:    sp_q <= {sp_q[15:1], 1'b0} - 16'd2;
            2'd2:    sp_q <= {sp_q[15:1], 1'b0} + 16'd2;
            default: sp_q <= {sp_q[15:1], 1'b0};
         endcase
      end
   end
   assign sp_in = sp_q;

   typedef struct {
      logic [2:0] op; logic [15:0] sp0, data, call, vec, pc, sr; int dly;
   } stim_t;
   typedef struct {
      logic err, pc_we, sr_we; logic [15:0] pc, sr, pop, sp; int lat, req;
   } exp_t;
   typedef struct { stim_t s; exp_t e; } vec_t;
   typedef struct { int idx; logic [15:0] a, d; } pre_t;
   typedef struct { int idx; logic we; logic [15:0] a, d; } xfer_t;

   localparam int NV = 11;
   vec_t  tbl [NV];
   pre_t  pre [6];
   xfer_t xf  [11];

   exp_t        exp_q [$];
   logic [63:0] xfer_q [$];
   logic [15:0] mem [logic [15:0]];

   int n_checks = 0;
   int n_err    = 0;
   int dly, req_cnt, req_cycles;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [15:0] rd_mem(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // Memory model, called once per cycle at the falling edge: decides the ack
   // for the current cycle and compares each completed transfer against the
   // scoreboard. A stray ack is driven whenever no request is pending.
   task automatic service();
      logic [63:0] act;
      check("MSP never 3", 64'(MSP == 2'd3), 64'd0);
      if (mem_req === 1'b1) begin
         req_cycles++;
         if (req_cnt == dly) begin
            mem_ack = 1'b1;
            req_cnt = 0;
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               mem_rdata = 16'hDEAD;
               act = {31'b0, 1'b1, mem_addr, mem_wdata};
            end else begin
               mem_rdata = rd_mem(mem_addr);
               act = {31'b0, 1'b0, mem_addr, mem_rdata};
            end
            if (xfer_q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL unexpected transfer: got %h expected none", act);
            end else begin
               check("transfer", act, xfer_q.pop_front());
            end
         end else begin
            mem_ack = 1'b0;
            mem_rdata = rd_mem(mem_addr);
            req_cnt++;
         end
      end else begin
         mem_ack = 1'b1;
         mem_rdata = 16'hDEAD;
         req_cnt = 0;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " MSP"}, 64'(MSP), 64'd0);
      check({tag, " sp_we"}, 64'(sp_we), 64'd0);
      check({tag, " mem_req"}, 64'(mem_req), 64'd0);
      check({tag, " mem_we"}, 64'(mem_we), 64'd0);
      check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, " pop_data"}, 64'(pop_data), 64'd0);
      check({tag, " pc_out"}, 64'(pc_out), 64'd0);
      check({tag, " pc_we"}, 64'(pc_we), 64'd0);
      check({tag, " sr_out"}, 64'(sr_out), 64'd0);
      check({tag, " sr_we"}, 64'(sr_we), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " err"}, 64'(err), 64'd0);
      check({tag, " op_ready"}, 64'(op_ready), 64'd1);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      exp_t e;
      int   cyc;
      bit   got;
      v = tbl[i];
      @(negedge clk);
      foreach (pre[k]) if (pre[k].idx == i) mem[pre[k].a] = pre[k].d;
      sp_load = 1'b1; sp_load_val = v.s.sp0;
      service();
      @(negedge clk);
      sp_load = 1'b0;
      dly = v.s.dly;
      op_valid = 1'b1; op = v.s.op; push_data = v.s.data; call_target = v.s.call;
      irq_vec = v.s.vec; pc_in = v.s.pc; sr_in = v.s.sr;
      exp_q.push_back(v.e);
      foreach (xf[k]) if (xf[k].idx == i) xfer_q.push_back({31'b0, xf[k].we, xf[k].a, xf[k].d});
      req_cycles = 0;
      check($sformatf("v%0d op_ready idle", i), 64'(op_ready), 64'd1);
      service();
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         op_valid = 1'b0;
         cyc++;
         service();
         if (done === 1'b1) got = 1'b1;
      end
      e = exp_q.pop_front();
      if (!got) begin
         check($sformatf("v%0d done seen", i), 64'd0, 64'd1);
      end else begin
         check($sformatf("v%0d latency", i), 64'(cyc), 64'(e.lat));
         check($sformatf("v%0d err", i), 64'(err), 64'(e.err));
         check($sformatf("v%0d pc_we", i), 64'(pc_we), 64'(e.pc_we));
         check($sformatf("v%0d sr_we", i), 64'(sr_we), 64'(e.sr_we));
         if (e.pc_we) check($sformatf("v%0d pc_out", i), 64'(pc_out), 64'(e.pc));
         if (e.sr_we) check($sformatf("v%0d sr_out", i), 64'(sr_out), 64'(e.sr));
         check($sformatf("v%0d pop_data", i), 64'(pop_data), 64'(e.pop));
         check($sformatf("v%0d req cycles", i), 64'(req_cycles), 64'(e.req));
         check($sformatf("v%0d op_ready in FIN", i), 64'(op_ready), 64'd0);
      end
      @(negedge clk);
      service();
      check($sformatf("v%0d op_ready after FIN", i), 64'(op_ready), 64'd1);
      check($sformatf("v%0d done one cycle", i), 64'(done), 64'd0);
      check($sformatf("v%0d SP", i), 64'(sp_q), 64'(e.sp));
      check($sformatf("v%0d transfers left", i), 64'(xfer_q.size()), 64'd0);
      xfer_q.delete();
   endtask

   initial begin
      rst = 1'b1; op_valid = 1'b0; op = '0; push_data = '0; call_target = '0;
      irq_vec = '0; pc_in = '0; sr_in = '0; mem_ack = 1'b0; mem_rdata = '0;
      sp_load = 1'b1; sp_load_val = 16'h0400; dly = 0; req_cnt = 0; req_cycles = 0;

      //          op       sp0       data      call      vec       pc        sr        dly    err pcwe srwe pc        sr        pop       sp        lat req
      tbl[0]  = '{'{OP_PUSH, 16'h0400, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h03FE, 3, 1}};
      tbl[1]  = '{'{OP_POP,  16'h03FE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'h0400, 7, 5}};
      tbl[2]  = '{'{OP_RETI, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0}, '{0, 1, 1, 16'hC000, 16'h0008, 16'h1234, 16'h0404, 5, 2}};
      tbl[3]  = '{'{OP_IRQ,  16'h0200, 16'h0000, 16'h0000, 16'hFFF2, 16'hC010, 16'h0009, 0}, '{0, 1, 0, 16'hD000, 16'h0000, 16'h1234, 16'h01FC, 6, 3}};
      tbl[4]  = '{'{OP_PUSH, 16'h0000, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'hFFFE, 3, 1}};
      tbl[5]  = '{'{3'd7,    16'h0600, 16'h1111, 16'h2222, 16'h3334, 16'h4444, 16'h5555, 0}, '{1, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'h0600, 1, 0}};
      tbl[6]  = '{'{OP_CALL, 16'h0300, 16'h0000, 16'hE000, 16'h0000, 16'hC100, 16'h0000, 1}, '{0, 1, 0, 16'hE000, 16'h0000, 16'h1234, 16'h02FE, 4, 2}};
      tbl[7]  = '{'{OP_NOP,  16'h0700, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 16'h0700, 1, 0}};
      tbl[8]  = '{'{OP_POP,  16'h0401, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h7777, 16'h0402, 5, 3}};
      tbl[9]  = '{'{OP_POP,  16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0}, '{0, 0, 0, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 3, 1}};
      tbl[10] = '{'{OP_POP,  16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, -1}, '{1, 0, 0, 16'h0000, 16'h0000, 16'h1111, 16'h0500, 9, 8}};

      pre[0] = '{1, 16'h03FE, 16'h1234};
      pre[1] = '{2, 16'h0400, 16'h0008};
      pre[2] = '{2, 16'h0402, 16'hC000};
      pre[3] = '{3, 16'hFFF2, 16'hD000};
      pre[4] = '{8, 16'h0400, 16'h7777};
      pre[5] = '{9, 16'hFFFE, 16'h1111};

      xf[0]  = '{0, 1'b1, 16'h03FE, 16'hBEEF};
      xf[1]  = '{1, 1'b0, 16'h03FE, 16'h1234};
      xf[2]  = '{2, 1'b0, 16'h0400, 16'h0008};
      xf[3]  = '{2, 1'b0, 16'h0402, 16'hC000};
      xf[4]  = '{3, 1'b1, 16'h01FE, 16'hC010};
      xf[5]  = '{3, 1'b1, 16'h01FC, 16'h0009};
      xf[6]  = '{3, 1'b0, 16'hFFF2, 16'hD000};
      xf[7]  = '{4, 1'b1, 16'hFFFE, 16'h5A5A};
      xf[8]  = '{6, 1'b1, 16'h02FE, 16'hC100};
      xf[9]  = '{8, 1'b0, 16'h0400, 16'h7777};
      xf[10] = '{9, 1'b0, 16'hFFFE, 16'h1111};

      repeat (2) begin @(negedge clk); service(); end
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0; sp_load = 1'b0;
      service();

      for (int i = 0; i < NV; i++) run_vec(i);

      // Reset while RETI is waiting on its first read: no done, outputs back
      // to reset values, SP untouched.
      @(negedge clk);
      sp_load = 1'b1; sp_load_val = 16'h0400;
      service();
      @(negedge clk);
      sp_load = 1'b0; dly = 100;
      op_valid = 1'b1; op = OP_RETI;
      service();
      repeat (2) begin
         @(negedge clk);
         op_valid = 1'b0;
         service();
      end
      check("mid-RETI busy", 64'(mem_req), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      service();
      check_reset("mid-RETI reset");
      check("mid-RETI SP", 64'(sp_q), 64'h0400);
      rst = 1'b0;
      @(negedge clk);
      service();
      check("post-reset done", 64'(done), 64'd0);
      check("post-reset op_ready", 64'(op_ready), 64'd1);

      // Recovery: a plain PUSH works after the abort.
      run_vec(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle stack sequencer for the MSP430 core. Runs PUSH, POP, CALL, RETI and interrupt-entry sequences.
- Each step either issues the 2-bit MSP select to the SP-update mux or performs one 16-bit memory transfer at the stack pointer.
- Sits between the instruction decoder/control unit and the data-memory port. It is the producer of MSP and the consumer of the updated SP.

Parameters:
- DW, 16, data/address width in bits.
- MAX_WAIT, 255, maximum cycles to wait for mem_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation request
- op_ready  out  1  high only in IDLE; a request is accepted when op_valid && op_ready at a rising edge
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RETI, 5 IRQ; 6-7 reserved
- push_data  in  DW  word to push; sampled at accept
- call_target  in  DW  CALL destination; sampled at accept
- irq_vec  in  DW  vector-table address for IRQ; sampled at accept
- pc_in  in  DW  current PC; sampled at accept
- sr_in  in  DW  current SR; sampled at accept
- sp_in  in  DW  current SP register value; live, not sampled
- MSP  out  2  SP mux select: 0 hold (forced even), 1 SP-2, 2 SP+2. Never 3.
- sp_we  out  1  SP register write enable
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DW  word address; bit 0 always 0
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data; valid in the ack cycle
- mem_ack  in  1  transfer complete
- pop_data  out  DW  result of POP; held until the next POP
- pc_out  out  DW  new PC
- pc_we  out  1  one-cycle PC load strobe
- sr_out  out  DW  new SR
- sr_we  out  1  one-cycle SR load strobe
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: reserved op or timeout

Behaviour:
- Reset outputs: MSP=0, sp_we=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pop_data=0, pc_out=0, pc_we=0, sr_out=0, sr_we=0, done=0, err=0, op_ready=1. State = IDLE, wait counter = 0.
- Reset mid-operation: abort immediately. No done pulse. SP and memory effects already committed stay committed.
- States: IDLE, DEC, WR, RD, INC, VEC, FIN.
- DEC (1 cycle): MSP=1, sp_we=1. SP register updates at the end of the cycle. Next state WR.
- WR: mem_req=1, mem_we=1, mem_addr={sp_in[DW-1:1],0}. Address and write data are held stable until mem_ack is sampled high.
- RD: mem_req=1, mem_we=0, mem_addr={sp_in[DW-1:1],0}. mem_rdata is captured in the ack cycle.
- INC (1 cycle): MSP=2, sp_we=1.
- Any state that is not asserting sp_we drives MSP=0.
- Operation sequences:
  - PUSH: DEC, WR(push_data), FIN.
  - POP: RD (into pop_data), INC, FIN.
  - CALL: DEC, WR(pc), FIN. FIN pulses pc_we with pc_out=call_target.
  - RETI: RD (into sr_out), INC, RD (into pc_out), INC, FIN. FIN pulses sr_we and pc_we together.
  - IRQ: DEC, WR(pc), DEC, WR(sr), VEC, FIN.
    - VEC is a read at mem_addr={irq_vec[DW-1:1],0} into pc_out.
    - FIN pulses pc_we. The core, not this block, clears SR GIE.
- A step counter inside the state machine selects the next state after each WR/RD/INC.
- FIN (1 cycle): done=1, then return to IDLE. op_ready is asserted in the cycle after FIN. Back-to-back operations therefore have a minimum spacing of one idle cycle.
- NOP: accepted, then FIN next cycle with err=0.
- Reserved op (6-7): accepted, then FIN next cycle with err=1. No SP or memory activity.
- Timeout: the wait counter resets on entry to WR/RD/VEC and increments every cycle without ack.
  - When the count reaches MAX_WAIT with MAX_WAIT≠0: drop mem_req, go to FIN with err=1, and no pc_we/sr_we.
  - An ack arriving in the same cycle as the limit counts as success.
- Minimum latency with ack in the first request cycle: PUSH 3, POP 3, CALL 3, RETI 5, IRQ 6 cycles from accept to done inclusive.
- SP arithmetic is modulo 2^DW in the mux:
  - 0x0000-2 = 0xFFFE.
  - 0xFFFE+2 = 0x0000.
  - Odd SP is treated as even.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package/header holds: op encodings (OP_NOP..OP_IRQ), MSP encodings (MSP_HOLD=0, MSP_DEC=1, MSP_INC=2), and state encodings.
- Optional sub-module stack_wait_timer: the MAX_WAIT counter with clear/enable/expired signals.
- The SP mux stays external; the bench instantiates it with the SP register.

Test Plan:
- SP=0x0400, PUSH 0xBEEF, ack immediate → write 0xBEEF @0x03FE, SP=0x03FE, done on 3rd cycle, err=0.
- SP=0x03FE, mem[0x03FE]=0x1234, POP with ack delayed 4 cycles → mem_req/addr held 5 cycles, pop_data=0x1234, SP=0x0400.
- SP=0x0400, mem[0x0400]=0x0008, mem[0x0402]=0xC000, RETI → sr_out=0x0008, pc_out=0xC000, SP=0x0404, pc_we and sr_we together in FIN.
- SP=0x0200, pc_in=0xC010, sr_in=0x0009, irq_vec=0xFFF2, mem[0xFFF2]=0xD000, IRQ → writes 0xC010@0x01FE and 0x0009@0x01FC, reads 0xFFF2, pc_out=0xD000, SP=0x01FC.
- SP=0x0000 PUSH → write @0xFFFE. Also: reserved op 7 → done with err=1, no mem_req, SP unchanged.
- MAX_WAIT=8, no ack on POP → done with err=1 after 8 wait cycles, SP unchanged. Also: rst asserted mid-RETI → all outputs at reset values next cycle, no done.
